// File: rtl/fp_mul_pipe_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pipe_param_pkg
//  Description : Shared types and helpers for the parametrised FP datapath:
//                rounding-mode encoding, operand classification, exception
//                flags and the per-mode round-increment decision.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_mul_pipe_param_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
    logic denorm;
  } fp_class_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic invalid;
  } fp_flags_t;

  // Unused encodings 5-7 fall back to round-to-nearest-even.
  function automatic rmode_e decode_rm(input logic [2:0] code);
    rmode_e rm;
    case (code)
      3'd1:    rm = RM_RTZ;
      3'd2:    rm = RM_RDN;
      3'd3:    rm = RM_RUP;
      3'd4:    rm = RM_RMM;
      default: rm = RM_RNE;
    endcase
    return rm;
  endfunction

  // Decide whether the kept significand is bumped by one ulp.
  function automatic logic round_up(input rmode_e rm, input logic sign, input logic lsb,
                                    input logic guard, input logic rnd, input logic sticky);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | rnd | sticky);
      RM_RUP:  inc = !sign & (guard | rnd | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (rnd | sticky | lsb);
    endcase
    return inc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_norm.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_norm
//  Description : Combinational normalise + round of a raw significand product.
//                Single-step normalisation (product in [1,4)), guard/round/
//                sticky extraction and rounding with carry into the exponent.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_round_norm
  import fp_mul_pipe_param_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0] prod,
  input  logic [EXP_W+1:0]   exp_in,
  input  logic               sign,
  input  rmode_e             rm,
  output logic [MAN_W-1:0]   frac,
  output logic [EXP_W+1:0]   exp_out,
  output logic               inexact
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;

  logic          w_msb;
  logic [PW-1:0] w_norm;
  logic [MAN_W:0] w_keep;
  logic          w_guard;
  logic          w_rnd;
  logic          w_sticky;
  logic          w_inc;
  logic          w_carry;

  // A product in [2,4) is shifted right by one; left-aligning the [1,2) case
  // instead lets both cases share the same bit slices below.
  assign w_msb    = prod[PW-1];
  assign w_norm   = w_msb ? prod : (prod << 1);
  assign w_keep   = w_norm[PW-1:MAN_W+1];
  assign w_guard  = w_norm[MAN_W];
  assign w_rnd    = w_norm[MAN_W-1];
  assign w_sticky = |w_norm[MAN_W-2:0];

  assign w_inc   = round_up(rm, sign, w_keep[0], w_guard, w_rnd, w_sticky);
  // Rounding carries out only when every kept bit is one; the fraction then wraps to zero.
  assign w_carry = w_inc & (&w_keep);

  assign frac    = w_keep[MAN_W-1:0] + MAN_W'(w_inc);
  assign exp_out = exp_in + XW'(w_msb) + XW'(w_carry);
  assign inexact = w_guard | w_rnd | w_sticky;

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pipe_param
//  Description : Four-stage pipelined IEEE-754 multiplier for any EXP_W/MAN_W
//                format. S1 classify, S2 multiply, S3 normalise/round,
//                S4 pack + flags. Valid/ready backpressure stalls all stages.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_mul_pipe_param
  import fp_mul_pipe_param_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   rounding_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         overflow,
  output logic         underflow,
  output logic         inexact,
  output logic         invalid_operation
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int XW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam logic [XW-1:0] BIAS_X  = XW'(BIAS);
  localparam logic [XW-1:0] EXP_MAX = XW'(2**EXP_W - 1);
  localparam logic [W-1:0]  QUIET_BIT  = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]  QNAN_CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic fp_class_t classify(input logic [W-1:0] x);
    fp_class_t c;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    c.zero   = (e == '0) && (m == '0);
    c.denorm = (e == '0) && (m != '0);
    c.inf    = (&e) && (m == '0);
    c.qnan   = (&e) && m[MAN_W-1];
    c.snan   = (&e) && (m != '0) && !m[MAN_W-1];
    return c;
  endfunction

  // ---------------- handshake ----------------
  logic w_adv;
  logic r_out_valid;
  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------- S1 classify (combinational front end) ----------------
  fp_class_t  w_c1, w_c2;
  logic       w_nan1, w_nan2, w_z1, w_z2, w_zero_inf, w_special, w_invalid, w_sign;
  logic [W-1:0] w_spec_res;

  assign w_c1       = classify(in1);
  assign w_c2       = classify(in2);
  assign w_nan1     = w_c1.qnan | w_c1.snan;
  assign w_nan2     = w_c2.qnan | w_c2.snan;
  // Denormals are flushed, so they behave as zero everywhere below.
  assign w_z1       = w_c1.zero | w_c1.denorm;
  assign w_z2       = w_c2.zero | w_c2.denorm;
  assign w_zero_inf = (w_z1 & w_c2.inf) | (w_c1.inf & w_z2);
  assign w_special  = w_nan1 | w_nan2 | w_c1.inf | w_c2.inf | w_z1 | w_z2;
  assign w_invalid  = w_c1.snan | w_c2.snan | w_zero_inf;
  assign w_sign     = in1[W-1] ^ in2[W-1];

  // Special-case result in priority order: NaN1, NaN2, 0*inf, inf, zero.
  always_comb begin
    w_spec_res = {w_sign, {(W-1){1'b0}}};
    if (w_nan1)
      w_spec_res = in1 | QUIET_BIT;
    else if (w_nan2)
      w_spec_res = in2 | QUIET_BIT;
    else if (w_zero_inf)
      w_spec_res = QNAN_CANON;
    else if (w_c1.inf | w_c2.inf)
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // ---------------- pipeline registers ----------------
  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic             r_s1_sign, r_s2_sign, r_s3_sign;
  logic             r_s1_special, r_s2_special, r_s3_special;
  logic             r_s1_invalid, r_s2_invalid, r_s3_invalid;
  logic [W-1:0]     r_s1_spec_res, r_s2_spec_res, r_s3_spec_res;
  rmode_e           r_s1_rm, r_s2_rm, r_s3_rm;
  logic [EXP_W-1:0] r_s1_e1, r_s1_e2;
  logic [MAN_W-1:0] r_s1_f1, r_s1_f2;
  logic [PW-1:0]    r_s2_prod;
  logic [XW-1:0]    r_s2_exp, r_s3_exp;
  logic [MAN_W-1:0] r_s3_frac;
  logic             r_s3_inexact;
  logic [W-1:0]     r_out;
  fp_flags_t        r_flags;

  logic [MAN_W-1:0] w_rn_frac;
  logic [XW-1:0]    w_rn_exp;
  logic             w_rn_inexact;

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .prod    (r_s2_prod),
    .exp_in  (r_s2_exp),
    .sign    (r_s2_sign),
    .rm      (r_s2_rm),
    .frac    (w_rn_frac),
    .exp_out (w_rn_exp),
    .inexact (w_rn_inexact)
  );

  // ---------------- S4 pack + flags (combinational) ----------------
  logic [W-1:0] w_pack_res;
  fp_flags_t    w_pack_flags;
  logic         w_to_max;

  // Special ops bypass the arithmetic; otherwise overflow/underflow/normal packing.
  always_comb begin
    w_pack_res   = '0;
    w_pack_flags = '0;
    w_to_max     = 1'b0;
    if (r_s3_special) begin
      w_pack_res           = r_s3_spec_res;
      w_pack_flags.invalid = r_s3_invalid;
    end else if (!r_s3_exp[XW-1] && (r_s3_exp >= EXP_MAX)) begin
      w_pack_flags.overflow = 1'b1;
      w_pack_flags.inexact  = 1'b1;
      case (r_s3_rm)
        RM_RTZ:  w_to_max = 1'b1;
        RM_RDN:  w_to_max = !r_s3_sign;
        RM_RUP:  w_to_max = r_s3_sign;
        default: w_to_max = 1'b0;
      endcase
      w_pack_res = w_to_max ? {r_s3_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                            : {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s3_exp[XW-1] || (r_s3_exp == '0)) begin
      w_pack_res             = {r_s3_sign, {(W-1){1'b0}}};
      w_pack_flags.underflow = 1'b1;
      w_pack_flags.inexact   = 1'b1;
    end else begin
      w_pack_res           = {r_s3_sign, r_s3_exp[EXP_W-1:0], r_s3_frac};
      w_pack_flags.inexact = r_s3_inexact;
    end
  end

  // Valid bits: cleared by reset, shifted in lockstep whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
    end
  end

  // Datapath stages S1-S3 advance together; contents of bubbles are don't-care.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_sign     <= w_sign;
      r_s1_special  <= w_special;
      r_s1_invalid  <= w_invalid;
      r_s1_spec_res <= w_spec_res;
      r_s1_rm       <= decode_rm(rounding_mode);
      r_s1_e1       <= in1[W-2:MAN_W];
      r_s1_e2       <= in2[W-2:MAN_W];
      r_s1_f1       <= in1[MAN_W-1:0];
      r_s1_f2       <= in2[MAN_W-1:0];

      r_s2_sign     <= r_s1_sign;
      r_s2_special  <= r_s1_special;
      r_s2_invalid  <= r_s1_invalid;
      r_s2_spec_res <= r_s1_spec_res;
      r_s2_rm       <= r_s1_rm;
      r_s2_prod     <= PW'({1'b1, r_s1_f1}) * PW'({1'b1, r_s1_f2});
      r_s2_exp      <= {2'b00, r_s1_e1} + {2'b00, r_s1_e2} - BIAS_X;

      r_s3_sign     <= r_s2_sign;
      r_s3_special  <= r_s2_special;
      r_s3_invalid  <= r_s2_invalid;
      r_s3_spec_res <= r_s2_spec_res;
      r_s3_rm       <= r_s2_rm;
      r_s3_frac     <= w_rn_frac;
      r_s3_exp      <= w_rn_exp;
      r_s3_inexact  <= w_rn_inexact;
    end
  end

  // Output register: held while the consumer stalls, zeroed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_out   <= w_pack_res;
      r_flags <= w_pack_flags;
    end
  end

  assign out_valid         = r_out_valid;
  assign out               = r_out;
  assign overflow          = r_flags.overflow;
  assign underflow         = r_flags.underflow;
  assign inexact           = r_flags.inexact;
  assign invalid_operation = r_flags.invalid;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mul_pipe_param
//  Description : Scoreboard bench for fp_mul_pipe_param in binary32 and
//                binary16 configurations with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_mul_pipe_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // binary32 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [2:0]  rm;
  logic        ovf, unf, inx, inv;

  // binary16 instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_y;
  logic [2:0]  h_rm;
  logic        h_ovf, h_unf, h_inx, h_inv;

  fp_mul_pipe_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(a), .in2(b), .rounding_mode(rm), .out_valid(out_valid),
    .out_ready(out_ready), .out(y), .overflow(ovf), .underflow(unf),
    .inexact(inx), .invalid_operation(inv)
  );

  fp_mul_pipe_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in1(h_a), .in2(h_b), .rounding_mode(h_rm), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out(h_y), .overflow(h_ovf), .underflow(h_unf),
    .inexact(h_inx), .invalid_operation(h_inv)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_accept = 0;

  logic [35:0] sp_q[$];
  string       sp_tag_q[$];
  logic [19:0] h_q[$];
  string       h_tag_q[$];
  logic [35:0] sp_exp;
  string       sp_tag;
  logic [19:0] h_exp;
  string       h_tag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // binary32 monitor: every accepted output is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sp_q.size() == 0) begin
        checks++;
        $display("FAIL sp_unexpected: got %h with no result pending", y);
      end else begin
        sp_exp = sp_q.pop_front();
        sp_tag = sp_tag_q.pop_front();
        check(sp_tag, {y, ovf, unf, inx, inv}, sp_exp);
      end
    end
  end

  // binary16 monitor
  always @(negedge clk) begin
    if (!rst && h_out_valid && h_out_ready) begin
      if (h_q.size() == 0) begin
        checks++;
        $display("FAIL h_unexpected: got %h with no result pending", h_y);
      end else begin
        h_exp = h_q.pop_front();
        h_tag = h_tag_q.pop_front();
        check(h_tag, {h_y, h_ovf, h_unf, h_inx, h_inv}, h_exp);
      end
    end
  end

  // Present one operand pair, hold until accepted, push its expected result.
  // flags are {overflow, underflow, inexact, invalid}.
  task automatic issue(input bit half, input logic [2:0] mode, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [31:0] res, input logic [3:0] fl,
                       input string tag);
    bit ok;
    ok = 1'b0;
    if (half) begin h_in_valid = 1'b1; h_a = x1[15:0]; h_b = x2[15:0]; h_rm = mode; end
    else begin in_valid = 1'b1; a = x1; b = x2; rm = mode; end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (half ? h_in_ready : in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      last_accept = cyc;
      if (half) begin h_q.push_back({res[15:0], fl}); h_tag_q.push_back(tag); end
      else begin sp_q.push_back({res, fl}); sp_tag_q.push_back(tag); end
    end else begin
      checks++;
      $display("FAIL %s: operands not accepted within 64 cycles", tag);
    end
    @(posedge clk); #1;
    if (half) h_in_valid = 1'b0; else in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (sp_q.size() != 0 || h_q.size() != 0); i++) @(negedge clk);
    check(tag, sp_q.size() + h_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid = 0; a = 0; b = 0; rm = 0; out_ready = 1;
    h_in_valid = 0; h_a = 0; h_b = 0; h_rm = 0; h_out_ready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flags", {y, ovf, unf, inx, inv}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_h_out_valid", h_out_valid, 0);
    rst = 1'b0;

    // latency: accept cycle t -> out_valid visible in cycle t+4
    issue(0, 3'd0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0, "mul_1p5x2");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", cyc - last_accept, 4);
    @(posedge clk); #1;

    // directed vectors, back to back
    issue(0, 3'd0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h2, "rne_tiny");
    issue(0, 3'd3, 32'h3F800001, 32'h3F800001, 32'h3F800003, 4'h2, "rup_tiny");
    issue(0, 3'd1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h2, "rtz_tiny");
    issue(0, 3'd4, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h2, "rmm_tiny");
    issue(0, 3'd5, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h2, "rm5_as_rne");
    issue(0, 3'd2, 32'h3F800001, 32'hBF800001, 32'hBF800003, 4'h2, "rdn_neg");
    issue(0, 3'd0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'hA, "ovf_rne");
    issue(0, 3'd1, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 4'hA, "ovf_rtz");
    issue(0, 3'd3, 32'hFF7FFFFF, 32'h40000000, 32'hFF7FFFFF, 4'hA, "ovf_rup_neg");
    issue(0, 3'd2, 32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'hA, "ovf_rdn_neg");
    issue(0, 3'd2, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 4'hA, "ovf_rdn_pos");
    issue(0, 3'd0, 32'h7F000001, 32'h3FFFFFFE, 32'h7F800000, 4'hA, "ovf_round_carry");
    issue(0, 3'd0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'h6, "underflow");
    issue(0, 3'd0, 32'h80800000, 32'h3F000000, 32'h80000000, 4'h6, "underflow_neg");
    issue(0, 3'd0, 32'h00800000, 32'h3F800000, 32'h00800000, 4'h0, "exp_one_normal");
    issue(0, 3'd0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'h0, "denorm_flush");
    issue(0, 3'd0, 32'h80000001, 32'h3F800000, 32'h80000000, 4'h0, "denorm_flush_neg");
    issue(0, 3'd0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h1, "zero_x_inf");
    issue(0, 3'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 4'h1, "snan1");
    issue(0, 3'd0, 32'hFFC00000, 32'h7F800001, 32'hFFC00000, 4'h1, "qnan1_snan2");
    issue(0, 3'd0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, "neg_inf");
    issue(0, 3'd0, 32'h40400000, 32'h40400000, 32'h41100000, 4'h0, "three_sq");
    issue(0, 3'd0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0, "neg_six");
    drain("drain_vectors");

    // backpressure: six ops while the consumer stalls for ten cycles
    fork
      begin
        issue(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40000000, 4'h0, "bp0");
        issue(0, 3'd0, 32'h3F800000, 32'h40400000, 32'h40400000, 4'h0, "bp1");
        issue(0, 3'd0, 32'h3F800000, 32'h40800000, 32'h40800000, 4'h0, "bp2");
        issue(0, 3'd0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 4'h0, "bp3");
        issue(0, 3'd0, 32'h3F800000, 32'h40C00000, 32'h40C00000, 4'h0, "bp4");
        issue(0, 3'd0, 32'h3F800000, 32'h40E00000, 32'h40E00000, 4'h0, "bp5");
      end
      begin
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (2) @(negedge clk);
        check("stall_out_held", y, 32'h40000000);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // reset while the pipe is full and stalled discards every op
    out_ready = 1'b0;
    issue(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40000000, 4'h0, "rs0");
    issue(0, 3'd0, 32'h3F800000, 32'h40400000, 32'h40400000, 4'h0, "rs1");
    issue(0, 3'd0, 32'h3F800000, 32'h40800000, 32'h40800000, 4'h0, "rs2");
    issue(0, 3'd0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 4'h0, "rs3");
    check("prerst_out_valid", out_valid, 1);
    check("prerst_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midstall_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    sp_q.delete();
    sp_tag_q.delete();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle", out_valid, 0);
    @(posedge clk); #1;

    // binary16 configuration
    issue(1, 3'd0, 32'h3C00, 32'h3C00, 32'h3C00, 4'h0, "h_one_x_one");
    issue(1, 3'd0, 32'h3E00, 32'h4000, 32'h4200, 4'h0, "h_1p5x2");
    issue(1, 3'd0, 32'h7BFF, 32'h4000, 32'h7C00, 4'hA, "h_ovf");
    issue(1, 3'd0, 32'h0000, 32'h7C00, 32'h7E00, 4'h1, "h_zero_x_inf");
    drain("drain_half");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
